// File: rtl/norm_sequencer.sv
// Time-multiplexes one external Normalize datapath over the N_CH channels of a frame; ch0 valid 2 cycles after accept.
// Output register holds under !i_ready, stalling the channel walk; define NORM_CLAMP_EN to saturate results to [-2048,2047].
module norm_sequencer #(
  parameter int N_CH = 8,
  parameter int W    = 16,
  parameter int CW   = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_we,
  input  logic              i_cfg_sel,
  input  logic [CW-1:0]     i_cfg_ch,
  input  logic [W-1:0]      i_cfg_data,
  input  logic              i_frame_valid,
  output logic              o_frame_ready,
  input  logic [N_CH*W-1:0] i_frame,
  output logic [W-1:0]      o_nd_data,
  output logic [W-1:0]      o_nd_mean,
  output logic [W-1:0]      o_nd_std,
  input  logic [W-1:0]      i_nd_norm,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W-1:0]      o_norm,
  output logic [CW-1:0]     o_ch,
  output logic              o_last,
  output logic              o_busy
);

  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_RUN  = 1'b1;
  localparam logic [CW:0] N_CH_W = (CW+1)'(N_CH);

  logic [0:0]    r_state;
  logic [CW-1:0] r_idx;
  logic [W-1:0]  r_frame [N_CH];
  logic [W-1:0]  r_mean  [N_CH];
  logic [W-1:0]  r_std   [N_CH];
  logic          r_valid;
  logic [W-1:0]  r_norm;
  logic [CW-1:0] r_ch;
  logic          r_last;

  logic          w_run;
  logic          w_cap;
  logic          w_idx_last;
  logic          w_cfg_ok;
  logic [W-1:0]  w_cap_val;

  assign w_run      = (r_state == S_RUN);
  assign w_cap      = w_run && (!r_valid || i_ready);
  assign w_idx_last = (r_idx == CW'(N_CH-1));
  assign w_cfg_ok   = (r_state == S_IDLE) && i_cfg_we && ({1'b0, i_cfg_ch} < N_CH_W);

`ifdef NORM_CLAMP_EN
  localparam logic signed [W-1:0] SAT_HI = W'(2047);
  localparam logic signed [W-1:0] SAT_LO = W'(-2048);

  always_comb begin
    w_cap_val = i_nd_norm;
    if ($signed(i_nd_norm) > SAT_HI)
      w_cap_val = SAT_HI;
    else if ($signed(i_nd_norm) < SAT_LO)
      w_cap_val = SAT_LO;
  end
`else
  assign w_cap_val = i_nd_norm;
`endif

  // Index rests at 0 in IDLE, so the datapath inputs follow channel 0 there.
  assign o_nd_data     = r_frame[r_idx];
  assign o_nd_mean     = r_mean[r_idx];
  assign o_nd_std      = r_std[r_idx];
  assign o_frame_ready = !w_run;
  assign o_busy        = w_run;
  assign o_valid       = r_valid;
  assign o_norm        = r_norm;
  assign o_ch          = r_ch;
  assign o_last        = r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_norm  <= '0;
      r_ch    <= '0;
      r_last  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_frame[i] <= '0;
        r_mean[i]  <= '0;
        r_std[i]   <= W'(1);
      end
    end else begin
      if (w_cfg_ok) begin
        if (i_cfg_sel)
          r_std[i_cfg_ch] <= (i_cfg_data == '0) ? W'(1) : i_cfg_data;
        else
          r_mean[i_cfg_ch] <= i_cfg_data;
      end

      case (r_state)
        S_IDLE: begin
          if (i_frame_valid) begin
            for (int i = 0; i < N_CH; i++)
              r_frame[i] <= i_frame[i*W +: W];
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_cap) begin
            if (w_idx_last) begin
              r_idx   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A capture refills the output register even when the old word drains this cycle.
      if (w_cap) begin
        r_valid <= 1'b1;
        r_norm  <= w_cap_val;
        r_ch    <= r_idx;
        r_last  <= w_idx_last;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_norm_sequencer.sv
// Randomized bench for norm_sequencer with a behavioural Normalize datapath and a frame-level scoreboard.
module tb_norm_sequencer;

  localparam int N_CH = 8;
  localparam int W    = 16;
  localparam int CW   = 3;

  logic              clk;
  logic              i_rst;
  logic              i_cfg_we;
  logic              i_cfg_sel;
  logic [CW-1:0]     i_cfg_ch;
  logic [W-1:0]      i_cfg_data;
  logic              i_frame_valid;
  logic              o_frame_ready;
  logic [N_CH*W-1:0] i_frame;
  logic [W-1:0]      o_nd_data;
  logic [W-1:0]      o_nd_mean;
  logic [W-1:0]      o_nd_std;
  logic [W-1:0]      i_nd_norm;
  logic              o_valid;
  logic              i_ready;
  logic [W-1:0]      o_norm;
  logic [CW-1:0]     o_ch;
  logic              o_last;
  logic              o_busy;

  norm_sequencer #(.N_CH(N_CH), .W(W), .CW(CW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel), .i_cfg_ch(i_cfg_ch), .i_cfg_data(i_cfg_data),
    .i_frame_valid(i_frame_valid), .o_frame_ready(o_frame_ready), .i_frame(i_frame),
    .o_nd_data(o_nd_data), .o_nd_mean(o_nd_mean), .o_nd_std(o_nd_std), .i_nd_norm(i_nd_norm),
    .o_valid(o_valid), .i_ready(i_ready), .o_norm(o_norm), .o_ch(o_ch), .o_last(o_last),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Normalize: ((data - mean) << 8) / std, signed, truncated toward zero, low 16 bits.
  function automatic logic [15:0] nd_fn(input logic [15:0] d, input logic [15:0] m, input logic [15:0] s);
    longint num;
    longint q;
    if (s == 16'h0) return 16'h0;
    num = (longint'($signed(d)) - longint'($signed(m))) * 256;
    q   = num / longint'({48'd0, s});
    return q[15:0];
  endfunction

  always_comb i_nd_norm = nd_fn(o_nd_data, o_nd_mean, o_nd_std);

  function automatic logic [15:0] ref_norm(input logic [15:0] d, input logic [15:0] m, input logic [15:0] s);
    logic [15:0] v;
    v = nd_fn(d, m, s);
`ifdef NORM_CLAMP_EN
    if (int'($signed(v)) > 2047)       v = 16'h07FF;
    else if (int'($signed(v)) < -2048) v = 16'hF800;
`endif
    return v;
  endfunction

  typedef struct {
    logic [15:0] norm;
    logic [2:0]  ch;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_mean [N_CH];
  logic [15:0] m_std  [N_CH];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  int          n_pushed = 0;
  int          n_cleared = 0;
  logic        rdy_rand  = 1'b0;
  logic        rdy_force = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_mean[i] = 16'h0;
      m_std[i]  = 16'h1;
    end
  endtask

  task automatic cfg_write(input logic sel, input int ch, input logic [15:0] data, input bit accept);
    i_cfg_we   = 1'b1;
    i_cfg_sel  = sel;
    i_cfg_ch   = 3'(ch);
    i_cfg_data = data;
    if (accept) begin
      if (sel) m_std[ch] = (data == 16'h0) ? 16'h1 : data;
      else     m_mean[ch] = data;
    end
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic send_frame(input logic [N_CH*W-1:0] f);
    bit acc;
    exp_t e;
    acc = 0;
    i_frame       = f;
    i_frame_valid = 1'b1;
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clk);
      if (o_frame_ready) begin
        acc = 1;
        for (int k = 0; k < N_CH; k++) begin
          e.norm = ref_norm(f[k*W +: W], m_mean[k], m_std[k]);
          e.ch   = 3'(k);
          e.last = (k == N_CH-1);
          exp_q.push_back(e);
          n_pushed++;
        end
      end
      tick();
    end
    i_frame_valid = 1'b0;
    check_eq("frame_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_out(input int ch);
    bit found;
    found = 0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      if (o_valid && o_ch == 3'(ch)) found = 1;
      else tick();
    end
    check_eq("wait_out_ch", 32'(found), 32'd1);
  endtask

  task automatic wait_idle();
    bit found;
    found = 0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_valid) found = 1;
      tick();
    end
    check_eq("wait_idle", 32'(found), 32'd1);
  endtask

  function automatic logic [N_CH*W-1:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output scoreboard plus hold-under-backpressure check.
  logic        prev_stall = 1'b0;
  logic [15:0] h_norm;
  logic [2:0]  h_ch;
  logic        h_last;
  always @(negedge clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(o_valid), 32'd1);
        check_eq("hold_norm", 32'(o_norm), 32'(h_norm));
        check_eq("hold_ch", 32'(o_ch), 32'(h_ch));
        check_eq("hold_last", 32'(o_last), 32'(h_last));
      end
      if (o_valid && i_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("out_norm", 32'(o_norm), 32'(e.norm));
          check_eq("out_ch", 32'(o_ch), 32'(e.ch));
          check_eq("out_last", 32'(o_last), 32'(e.last));
        end
      end
      prev_stall = o_valid && !i_ready;
      h_norm = o_norm;
      h_ch   = o_ch;
      h_last = o_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_CH*W-1:0] f;
    i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_sel = 1'b0; i_cfg_ch = '0; i_cfg_data = '0;
    i_frame_valid = 1'b0; i_frame = '0; i_ready = 1'b1;
    model_reset();
    tick(); tick();
    i_rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_norm", 32'(o_norm), 32'd0);
    check_eq("rst_ch", 32'(o_ch), 32'd0);
    check_eq("rst_last", 32'(o_last), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_frame_ready", 32'(o_frame_ready), 32'd1);
    tick();

    // Latency and the -69 / mean 7 / std 3 vector.
    cfg_write(1'b0, 0, 16'd7, 1);
    cfg_write(1'b1, 0, 16'd3, 1);
    f = '0; f[15:0] = 16'hFFBB;
    send_frame(f);
    @(negedge clk);
    check_eq("lat_t1_valid", 32'(o_valid), 32'd0);
    check_eq("lat_t1_busy", 32'(o_busy), 32'd1);
    check_eq("lat_t1_frame_ready", 32'(o_frame_ready), 32'd0);
    tick();
    for (int k = 0; k < N_CH; k++) begin
      @(negedge clk);
      check_eq("lat_valid", 32'(o_valid), 32'd1);
      check_eq("lat_ch", 32'(o_ch), 32'(k));
      check_eq("lat_last", 32'(o_last), 32'(k == N_CH-1));
      check_eq("lat_norm", 32'(o_norm), (k == 0) ? 32'hE6AB : 32'h0);
      if (k == N_CH-1) check_eq("lat_frame_ready_last", 32'(o_frame_ready), 32'd1);
      tick();
    end
    wait_idle();

    // std write of 0 stores 1.
    cfg_write(1'b1, 2, 16'd0, 1);
    f = '0; f[47:32] = 16'd5;
    send_frame(f);
    wait_out(2);
    check_eq("std0_guard", 32'(o_norm), 32'h0500);
    tick();
    wait_idle();

    // Three-cycle stall while ch3 is presented.
    send_frame(rand_frame());
    wait_out(2);
    rdy_force = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(o_valid), 32'd1);
      check_eq("stall_ch", 32'(o_ch), 32'd3);
      if (i == 2) rdy_force = 1'b1;
      tick();
    end
    wait_out(4);
    tick();
    wait_idle();

    // Config write in RUN is dropped.
    send_frame(rand_frame());
    cfg_write(1'b0, 1, 16'h0100, 0);
    wait_idle();
    f = '0; f[31:16] = 16'd3;
    send_frame(f);
    wait_out(1);
    check_eq("run_cfg_ignored", 32'(o_norm), 32'h0300);
    tick();
    wait_idle();

    // Saturation boundary.
    f = '0; f[63:48] = 16'd100;
    send_frame(f);
    wait_out(3);
`ifdef NORM_CLAMP_EN
    check_eq("clamp_100", 32'(o_norm), 32'h07FF);
`else
    check_eq("clamp_100", 32'(o_norm), 32'h6400);
`endif
    tick();
    wait_idle();

    // Reset after ch4 has been delivered.
    send_frame(rand_frame());
    wait_out(4);
    tick();
    i_rst = 1'b1;
    @(negedge clk);
    tick();
    i_rst = 1'b0;
    n_cleared += exp_q.size();
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check_eq("midrst_valid", 32'(o_valid), 32'd0);
    check_eq("midrst_frame_ready", 32'(o_frame_ready), 32'd1);
    check_eq("midrst_busy", 32'(o_busy), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_quiet", 32'(o_valid), 32'd0);
      tick();
    end
    f = '0; f[15:0] = 16'd1;
    send_frame(f);
    wait_out(0);
    check_eq("midrst_tables", 32'(o_norm), 32'h0100);
    tick();
    wait_idle();

    // Randomized traffic.
    rdy_rand = 1'b1;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        for (int c = 0; c < 3; c++) begin
          logic s;
          s = 1'($urandom_range(0, 1));
          cfg_write(s, int'($urandom_range(0, N_CH-1)),
                    (s && $urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 1);
        end
      end
      send_frame(rand_frame());
      if ($urandom_range(0, 1) == 1)
        cfg_write(1'($urandom_range(0, 1)), int'($urandom_range(0, N_CH-1)), 16'($urandom), 0);
    end
    wait_idle();
    rdy_rand = 1'b0;
    tick();

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("out_count", 32'(n_out), 32'(n_pushed - n_cleared));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
